// File: rtl/pipe_idexe_fwd.sv
// ID/EXE pipeline register with MEM/WB operand forwarding, load-use stall
// detection and bubble insertion on cancel.
module pipe_idexe_fwd #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cancel,
  input  logic          d_valid,
  input  logic [DW-1:0] d_qa,
  input  logic [DW-1:0] d_qb,
  input  logic [DW-1:0] d_imm,
  input  logic [4:0]    d_sa,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic [RW-1:0] d_rn,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [3:0]    d_aluc,
  input  logic          d_aluimm,
  input  logic          d_shift,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          d_wmem,
  input  logic [RW-1:0] m_rn,
  input  logic          m_wreg,
  input  logic          m_m2reg,
  input  logic [DW-1:0] m_alu,
  input  logic [RW-1:0] w_rn,
  input  logic          w_wreg,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] e_a,
  output logic [DW-1:0] e_b,
  output logic [3:0]    e_aluc,
  output logic [DW-1:0] e_st_data,
  output logic [RW-1:0] e_rn,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic          e_valid,
  output logic          stall
);

  logic          valid_q,  valid_d;
  logic [DW-1:0] qa_q,     qa_d;
  logic [DW-1:0] qb_q,     qb_d;
  logic [DW-1:0] imm_q,    imm_d;
  logic [4:0]    sa_q,     sa_d;
  logic [RW-1:0] rs_q,     rs_d;
  logic [RW-1:0] rt_q,     rt_d;
  logic [RW-1:0] rn_q,     rn_d;
  logic          use_rs_q, use_rs_d;
  logic          use_rt_q, use_rt_d;
  logic [3:0]    aluc_q,   aluc_d;
  logic          aluimm_q, aluimm_d;
  logic          shift_q,  shift_d;
  logic          wreg_q,   wreg_d;
  logic          m2reg_q,  m2reg_d;
  logic          wmem_q,   wmem_d;

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          m_fwd_ok;
  logic          w_fwd_ok;
  logic          m_load;

  // Register 0 is hard-wired zero, so a producer targeting it never forwards.
  assign m_fwd_ok = m_wreg & ~m_m2reg & (m_rn != '0);
  assign w_fwd_ok = w_wreg & (w_rn != '0);
  assign m_load   = m_wreg & m_m2reg & (m_rn != '0);

  always_comb begin
    fwd_rs = qa_q;
    if (m_fwd_ok && (m_rn == rs_q))      fwd_rs = m_alu;
    else if (w_fwd_ok && (w_rn == rs_q)) fwd_rs = w_data;

    fwd_rt = qb_q;
    if (m_fwd_ok && (m_rn == rt_q))      fwd_rt = m_alu;
    else if (w_fwd_ok && (w_rn == rt_q)) fwd_rt = w_data;
  end

  // A load in MEM cannot supply data yet; hold one cycle until it reaches WB.
  assign stall = valid_q & m_load &
                 ((use_rs_q & (m_rn == rs_q)) | (use_rt_q & (m_rn == rt_q)));

  assign e_valid   = valid_q & ~stall;
  assign e_wreg    = wreg_q  & e_valid;
  assign e_wmem    = wmem_q  & e_valid;
  assign e_m2reg   = m2reg_q & e_valid;
  assign e_a       = shift_q  ? {{(DW-5){1'b0}}, sa_q} : fwd_rs;
  assign e_b       = aluimm_q ? imm_q : fwd_rt;
  assign e_st_data = fwd_rt;
  assign e_aluc    = aluc_q;
  assign e_rn      = rn_q;

  // Cancel only kills the control state; datapath fields hold, as they are
  // ignored while valid is low.
  always_comb begin
    valid_d  = valid_q;
    qa_d     = qa_q;
    qb_d     = qb_q;
    imm_d    = imm_q;
    sa_d     = sa_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rn_d     = rn_q;
    use_rs_d = use_rs_q;
    use_rt_d = use_rt_q;
    aluc_d   = aluc_q;
    aluimm_d = aluimm_q;
    shift_d  = shift_q;
    wreg_d   = wreg_q;
    m2reg_d  = m2reg_q;
    wmem_d   = wmem_q;
    if (cancel) begin
      valid_d = 1'b0;
      wreg_d  = 1'b0;
      m2reg_d = 1'b0;
      wmem_d  = 1'b0;
    end else if (!stall) begin
      valid_d  = d_valid;
      qa_d     = d_qa;
      qb_d     = d_qb;
      imm_d    = d_imm;
      sa_d     = d_sa;
      rs_d     = d_rs;
      rt_d     = d_rt;
      rn_d     = d_rn;
      use_rs_d = d_use_rs;
      use_rt_d = d_use_rt;
      aluc_d   = d_aluc;
      aluimm_d = d_aluimm;
      shift_d  = d_shift;
      wreg_d   = d_wreg;
      m2reg_d  = d_m2reg;
      wmem_d   = d_wmem;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q  <= 1'b0;
      qa_q     <= '0;
      qb_q     <= '0;
      imm_q    <= '0;
      sa_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rn_q     <= '0;
      use_rs_q <= 1'b0;
      use_rt_q <= 1'b0;
      aluc_q   <= '0;
      aluimm_q <= 1'b0;
      shift_q  <= 1'b0;
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      qa_q     <= qa_d;
      qb_q     <= qb_d;
      imm_q    <= imm_d;
      sa_q     <= sa_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rn_q     <= rn_d;
      use_rs_q <= use_rs_d;
      use_rt_q <= use_rt_d;
      aluc_q   <= aluc_d;
      aluimm_q <= aluimm_d;
      shift_q  <= shift_d;
      wreg_q   <= wreg_d;
      m2reg_q  <= m2reg_d;
      wmem_q   <= wmem_d;
    end
  end

endmodule

// File: tb/tb_pipe_idexe_fwd.sv
// Directed self-checking bench for pipe_idexe_fwd.
module tb_pipe_idexe_fwd;

  logic        clk = 1'b0;
  logic        clrn, cancel, d_valid;
  logic [31:0] d_qa, d_qb, d_imm;
  logic [4:0]  d_sa, d_rs, d_rt, d_rn;
  logic        d_use_rs, d_use_rt;
  logic [3:0]  d_aluc;
  logic        d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem;
  logic [4:0]  m_rn, w_rn;
  logic        m_wreg, m_m2reg, w_wreg;
  logic [31:0] m_alu, w_data;
  logic [31:0] e_a, e_b, e_st_data;
  logic [3:0]  e_aluc;
  logic [4:0]  e_rn;
  logic        e_wreg, e_m2reg, e_wmem, e_valid, stall;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_idexe_fwd #(.DW(32), .RW(5)) dut (
    .clk(clk), .clrn(clrn), .cancel(cancel), .d_valid(d_valid),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa),
    .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_aluc(d_aluc),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_wreg(d_wreg),
    .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .m_rn(m_rn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu),
    .w_rn(w_rn), .w_wreg(w_wreg), .w_data(w_data),
    .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_st_data(e_st_data),
    .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_valid(e_valid), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic d_clear();
    d_valid = 0; d_qa = 0; d_qb = 0; d_imm = 0; d_sa = 0;
    d_rs = 0; d_rt = 0; d_rn = 0; d_use_rs = 0; d_use_rt = 0;
    d_aluc = 0; d_aluimm = 0; d_shift = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0;
  endtask

  task automatic mw_clear();
    m_rn = 0; m_wreg = 0; m_m2reg = 0; m_alu = 0;
    w_rn = 0; w_wreg = 0; w_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cancel = 0;
    clrn = 0;
    // Reset with random inputs: all outputs must be zero.
    d_valid = 1; d_qa = $urandom; d_qb = $urandom; d_imm = $urandom;
    d_sa = 5'($urandom); d_rs = 5'($urandom); d_rt = 5'($urandom);
    d_rn = 5'($urandom); d_use_rs = 1; d_use_rt = 1; d_aluc = 4'($urandom);
    d_aluimm = 1; d_shift = 1; d_wreg = 1; d_m2reg = 1; d_wmem = 1;
    m_rn = 5'($urandom); m_wreg = 1; m_m2reg = 1; m_alu = $urandom;
    w_rn = 5'($urandom); w_wreg = 1; w_data = $urandom;
    tick();
    tick();
    chk("rst_e_a", e_a, 0);
    chk("rst_e_b", e_b, 0);
    chk("rst_st", e_st_data, 0);
    chk("rst_valid", {31'b0, e_valid}, 0);
    chk("rst_ctl", {29'b0, e_wreg, e_m2reg, e_wmem}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_rn_aluc", {23'b0, e_rn, e_aluc}, 0);

    // First instruction after release.
    d_clear(); mw_clear();
    d_valid = 1; d_qa = 5; d_qb = 7; d_rs = 1; d_rt = 2; d_rn = 6;
    d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    #2 clrn = 1;
    tick();
    chk("t1_e_a", e_a, 5);
    chk("t1_e_b", e_b, 7);
    chk("t1_valid", {31'b0, e_valid}, 1);
    chk("t1_wreg", {31'b0, e_wreg}, 1);
    chk("t1_rn", {27'b0, e_rn}, 6);

    // MEM beats WB; WB beats register file.
    d_clear();
    d_valid = 1; d_rs = 3; d_qa = 32'h11; d_rt = 4; d_qb = 32'h44;
    d_use_rs = 1; d_use_rt = 1; d_wreg = 1;
    tick();
    m_rn = 3; m_wreg = 1; m_m2reg = 0; m_alu = 32'h1234;
    w_rn = 3; w_wreg = 1; w_data = 32'h9999;
    #1;
    chk("t2_mem_fwd", e_a, 32'h1234);
    chk("t2_st_nofwd", e_st_data, 32'h44);
    m_wreg = 0; #1;
    chk("t2_wb_fwd", e_a, 32'h9999);
    w_wreg = 0; #1;
    chk("t2_nofwd", e_a, 32'h11);
    w_rn = 4; w_wreg = 1; w_data = 32'hABCD; #1;
    chk("t2_wb_rt", e_b, 32'hABCD);

    // Load-use on rt.
    d_clear(); mw_clear();
    d_valid = 1; d_rs = 9; d_qa = 1; d_rt = 8; d_qb = 32'h55;
    d_use_rs = 1; d_use_rt = 1; d_wreg = 1; d_aluc = 4'h5; d_rn = 12;
    tick();
    m_rn = 8; m_wreg = 1; m_m2reg = 1; m_alu = 32'h7777;
    d_qb = 32'h77; d_rt = 10; d_aluc = 4'hA; d_rn = 13;
    #1;
    chk("t3_stall", {31'b0, stall}, 1);
    chk("t3_wreg_gated", {31'b0, e_wreg}, 0);
    chk("t3_valid_gated", {31'b0, e_valid}, 0);
    tick();
    mw_clear();
    w_rn = 8; w_wreg = 1; w_data = 32'hCAFE;
    #1;
    chk("t3_wb_b", e_b, 32'hCAFE);
    chk("t3_nostall", {31'b0, stall}, 0);
    chk("t3_hold_aluc", {28'b0, e_aluc}, 32'h5);
    chk("t3_hold_rn", {27'b0, e_rn}, 12);
    chk("t3_valid", {31'b0, e_wreg}, 1);

    // Register 0 never forwards nor stalls.
    d_clear(); mw_clear();
    d_valid = 1; d_use_rs = 1; d_use_rt = 1;
    tick();
    m_rn = 0; m_wreg = 1; m_m2reg = 1; m_alu = 32'hDEAD;
    w_rn = 0; w_wreg = 1; w_data = 32'hBEEF;
    #1;
    chk("t4_stall0", {31'b0, stall}, 0);
    chk("t4_e_a0", e_a, 0);
    m_m2reg = 0; #1;
    chk("t4_e_b0", e_b, 0);

    // Cancel wins over stall.
    d_clear(); mw_clear();
    d_valid = 1; d_rt = 8; d_use_rt = 1; d_wreg = 1; d_wmem = 1;
    tick();
    m_rn = 8; m_wreg = 1; m_m2reg = 1;
    #1;
    chk("t5_stall", {31'b0, stall}, 1);
    cancel = 1;
    tick();
    cancel = 0;
    #1;
    chk("t5_valid", {31'b0, e_valid}, 0);
    chk("t5_ctl", {30'b0, e_wreg, e_wmem}, 0);
    chk("t5_stall_drop", {31'b0, stall}, 0);

    // Shift amount and immediate select.
    d_clear(); mw_clear();
    d_valid = 1; d_shift = 1; d_sa = 4; d_aluimm = 1; d_imm = 32'hFFFF0000;
    d_qa = 32'h1111; d_qb = 32'h2222; d_m2reg = 1; d_wreg = 1;
    tick();
    chk("t6_e_a", e_a, 4);
    chk("t6_e_b", e_b, 32'hFFFF0000);
    chk("t6_st", e_st_data, 32'h2222);
    chk("t6_m2reg", {31'b0, e_m2reg}, 1);

    // Async reset during a stall.
    d_clear(); mw_clear();
    d_valid = 1; d_rs = 7; d_use_rs = 1; d_qa = 32'h42;
    tick();
    m_rn = 7; m_wreg = 1; m_m2reg = 1;
    #1;
    chk("t7_stall", {31'b0, stall}, 1);
    #1 clrn = 0;
    #1;
    chk("t7_rst_stall", {31'b0, stall}, 0);
    chk("t7_rst_a", e_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
